uart_tx_fifo_reader: RTL and testbench
======================================

Name: uart_tx_fifo_reader

Overview:
- UART 8N1 transmitter that acts as the read side of the team's FIFO pointer-control interface.
- It pops bytes from the TX FIFO whenever the FIFO is non-empty and serialises them onto the tx line, LSB first.
- Bit timing comes from an external oversampling baud tick, the same tick that feeds the RX path.
- It sits between the TX FIFO (data/empty outputs) and the board UART pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- OVERSAMPLE, 16, b_tick pulses per bit period; must be ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- b_tick  input  1  one-clk-wide pulse at OVERSAMPLE × baud rate.
- fifo_empty  input  1  FIFO empty flag. Registered in the FIFO.
- fifo_rdata  input  DATA_WIDTH  word at the FIFO read pointer. Valid whenever fifo_empty=0 (first-word fall-through).
- fifo_rd  output  1  pop strobe to the FIFO. Registered, one clk wide.
- tx  output  1  serial line. Registered, idles high.
- tx_busy  output  1  high while a frame is in progress (state≠IDLE).
- tx_done  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset, asynchronous: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done=0; tick and bit counters=0; shift register=0.
- States: IDLE, START, DATA, STOP. State and all outputs are registered.
- IDLE:
  - tx=1.
  - If fifo_empty=0 on clk edge N: latch fifo_rdata into the shift register, go to START, and set fifo_rd=1 for the cycle after edge N only.
  - At that edge tx goes to 0 and tx_busy goes to 1.
  - Exactly one pop per frame; fifo_rd is never asserted outside the IDLE→START transition.
- START: tx=0. Count b_tick pulses. On the OVERSAMPLE-th pulse: clear the tick counter, go to DATA, bit index=0.
- DATA:
  - tx=shift_reg[0].
  - On the OVERSAMPLE-th b_tick: shift right by 1 and clear the tick counter.
  - If bit index=DATA_WIDTH-1, go to STOP; else increment the bit index.
- STOP: tx=1. On the OVERSAMPLE-th b_tick: go to IDLE and pulse tx_done for one clk.
- Frame length = (DATA_WIDTH+2)×OVERSAMPLE b_ticks. The first bit may be short by less than one b_tick period, because the frame starts on a clk edge, not on a tick.
- Back-to-back:
  - After STOP→IDLE, the FIFO is re-checked on the next clk edge.
  - The minimum idle-high gap between frames is 1 clk plus the start-tick alignment.
  - No extra stop bits are inserted.
- b_tick while IDLE is ignored; the tick counter holds at 0.
- Counter widths:
  - tick counter $clog2(OVERSAMPLE).
  - bit index $clog2(DATA_WIDTH), with a minimum of 1 bit.
  - Counters compare against OVERSAMPLE-1 / DATA_WIDTH-1; no wrap-around beyond these values.
- fifo_empty rising mid-frame: no effect; the frame in flight completes.
- fifo_rdata changing mid-frame: no effect; data was latched at the pop.
- b_tick and the state transition on the same edge: the tick is consumed by the current state. The counter cleared on a transition starts counting from the next tick.
- Reset mid-frame:
  - tx returns high immediately.
  - The frame is aborted and the popped byte is lost.
  - No pop is issued during reset or on the first cycle after it.
- b_tick held high continuously (test mode): every clk counts as a tick; the FSM remains correct.

Decomposition:
- Package uart_pkg: typedef enum logic [1:0] tx_state_e {IDLE, START, DATA, STOP}; localparam UART_DATA_WIDTH=8, UART_OVERSAMPLE=16, shared with the RX.
- No sub-module; the block is a single FSM plus datapath.
- The baud tick generator and FIFO are instantiated at the level above.

Test Plan:
- Single byte. DATA_WIDTH=8, OVERSAMPLE=16, b_tick every 4 clks; FIFO holds 0xA5.
  - Required tx: 0 | 1,0,1,0,0,1,0,1 | 1, each bit 64 clks.
  - fifo_rd is high exactly one clk, coinciding with the first tx=0 cycle.
  - tx_done pulses once after 640 clks.
- Empty FIFO: fifo_empty=1 for 2000 clks with b_tick running → tx=1, fifo_rd=0, tx_busy=0 throughout.
- Back-to-back: FIFO holds 0x00, 0xFF.
  - Exactly 2 fifo_rd pulses.
  - Frames decode as 0x00 then 0xFF.
  - Gap between the first stop bit and the second start bit is ≤ 1 clk + 4 clks.
  - tx_done pulses twice.
- Mid-frame disturbance: after popping 0x3C, set fifo_empty=1 and fifo_rdata=0xFF at bit 3 → the line still shows 0x3C, and there is no further fifo_rd.
- Reset mid-frame: assert rst during bit 4 of 0x55.
  - tx=1, fifo_rd=0, tx_busy=0 asynchronously.
  - After release, with the FIFO holding 0x81, the next frame is a clean 0x81.
- b_tick tied high, OVERSAMPLE=16, byte 0x01 → each bit lasts 16 clks; total frame is 160 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths.
// Frame geometry defaults and the transmitter state encoding.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART 8N1 transmitter draining a first-word fall-through TX FIFO.
// Bit timing is taken from the shared oversampling baud tick.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  b_tick,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW =
    ($clog2(DATA_WIDTH) < 1) ? 1 : $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic                  tick_last;

  assign shreg_nxt = shreg >> 1;
  assign tick_last = b_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      fifo_rd  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          tick_cnt <= '0;
          bit_idx  <= '0;
          // Pop and launch the start bit on the same edge.
          if (!fifo_empty) begin
            shreg   <= fifo_rdata;
            state   <= START;
            fifo_rd <= 1'b1;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick_last) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick_cnt <= '0;
            shreg    <= shreg_nxt;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg_nxt[0];
            end
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick_last) begin
            tick_cnt <= '0;
            state    <= IDLE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench: FIFO model, line decoder, vector table
// and randomized byte streams for uart_tx_fifo_reader.
module tb_uart_tx_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_reader dut (
    .clk(clk),
    .rst(rst),
    .b_tick(b_tick),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int tick_mode = 0;
  int tick_ph = 0;
  int bp = 64;
  bit ovr = 1'b0;

  logic [7:0] q[$];
  int rd_cnt = 0;
  int rd_under = 0;

  logic [7:0] dec[$];
  int starts[$];
  int dones[$];
  int rd_misalign = 0;
  int frame_err = 0;
  bit in_frame = 1'b0;
  int st = 0;
  int off = 0;
  logic [7:0] sh = 8'h00;

  always @(posedge clk) cyc++;

  // Tick source and first-word fall-through FIFO model.
  always @(negedge clk) begin
    if (tick_mode == 1) begin
      b_tick = 1'b1;
    end else if (tick_mode > 1) begin
      tick_ph = (tick_ph + 1) % tick_mode;
      b_tick = (tick_ph == 0);
    end else begin
      b_tick = 1'b0;
    end
    if (fifo_rd === 1'b1) begin
      rd_cnt++;
      if (q.size() > 0) void'(q.pop_front());
      else rd_under++;
    end
    fifo_empty = ovr || (q.size() == 0);
    fifo_rdata = ovr ? 8'hFF : ((q.size() > 0) ? q[0] : 8'h00);
  end

  // Line decoder: samples each bit at its centre from the start edge.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (tx_done === 1'b1) dones.push_back(cyc);
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          st = cyc;
          starts.push_back(cyc);
          if (fifo_rd !== 1'b1) rd_misalign++;
        end
      end else begin
        off = cyc - st;
        if (off == bp / 2 && tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++)
          if (off == bp / 2 + (i + 1) * bp) sh[i] = tx;
        if (off == bp / 2 + 9 * bp) begin
          if (tx !== 1'b1) frame_err++;
          dec.push_back(sh);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic clr();
    rd_cnt = 0;
    rd_under = 0;
    rd_misalign = 0;
    frame_err = 0;
    dec.delete();
    starts.delete();
    dones.delete();
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(string nm, int n, int budget);
    int k = 0;
    while (dones.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done pulses by deadline"}, dones.size(), n);
  endtask

  task automatic wait_start(string nm, int n, int budget);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " start seen"}, starts.size(), n);
  endtask

  function automatic int first_dec();
    return (dec.size() > 0) ? int'(dec[0]) : -1;
  endfunction

  typedef struct {
    logic [7:0] data;
    int         period;
    int         dmin;
    int         dmax;
  } vec_t;

  vec_t vt[3];
  logic [7:0] expq[$];
  int bad;
  int n;

  initial begin
    vt[0] = '{8'hA5, 4, 637, 640};
    vt[1] = '{8'h01, 1, 160, 160};
    vt[2] = '{8'hC3, 2, 319, 320};

    #1 rst = 1'b1;
    idle(2);
    chk("reset tx", tx, 1);
    chk("reset fifo_rd", fifo_rd, 0);
    chk("reset busy", tx_busy, 0);
    chk("reset done", tx_done, 0);
    rst = 1'b0;
    idle(2);

    foreach (vt[v]) begin
      tick_mode = vt[v].period;
      bp = 16 * vt[v].period;
      clr();
      idle(2);
      q.push_back(vt[v].data);
      wait_done($sformatf("vec%0d", v), 1, 2000);
      idle(3);
      chk($sformatf("vec%0d frames", v), dec.size(), 1);
      chk($sformatf("vec%0d byte", v), first_dec(), int'(vt[v].data));
      chk($sformatf("vec%0d pops", v), rd_cnt, 1);
      chk($sformatf("vec%0d pop at start", v), rd_misalign, 0);
      chk($sformatf("vec%0d framing", v), frame_err, 0);
      chk($sformatf("vec%0d done count", v), dones.size(), 1);
      if (dones.size() > 0 && starts.size() > 0)
        chk_rng($sformatf("vec%0d frame clks", v),
                dones[0] - starts[0], vt[v].dmin, vt[v].dmax);
      chk($sformatf("vec%0d busy after", v), tx_busy, 0);
    end

    tick_mode = 4;
    bp = 64;
    clr();
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 ||
          tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("empty idle violations", bad, 0);

    clr();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    wait_start("b2b", 1, 50);
    idle(10);
    chk("b2b busy mid", tx_busy, 1);
    wait_done("b2b", 2, 2000);
    idle(3);
    chk("b2b pops", rd_cnt, 2);
    chk("b2b frames", dec.size(), 2);
    chk("b2b byte0", first_dec(), 8'h00);
    chk("b2b byte1", (dec.size() > 1) ? int'(dec[1]) : -1, 8'hFF);
    chk("b2b framing", frame_err, 0);
    if (starts.size() > 1 && dones.size() > 0)
      chk_rng("b2b gap", starts[1] - dones[0], 1, 5);

    clr();
    q.push_back(8'h3C);
    wait_start("disturb", 1, 50);
    while (starts.size() > 0 && cyc - starts[0] < 288) @(negedge clk);
    ovr = 1'b1;
    wait_done("disturb", 1, 1000);
    idle(50);
    chk("disturb byte", first_dec(), 8'h3C);
    chk("disturb pops", rd_cnt, 1);
    ovr = 1'b0;
    idle(5);

    clr();
    q.push_back(8'h55);
    wait_start("rst", 1, 50);
    while (starts.size() > 0 && cyc - starts[0] < 352) @(negedge clk);
    chk("rst busy before", tx_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst async tx", tx, 1);
    chk("rst async fifo_rd", fifo_rd, 0);
    chk("rst async busy", tx_busy, 0);
    clr();
    q.push_back(8'h81);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("rst hold quiet", bad, 0);
    rst = 1'b0;
    #1;
    chk("rst release no pop", fifo_rd, 0);
    wait_done("post rst", 1, 1000);
    idle(3);
    chk("post rst frames", dec.size(), 1);
    chk("post rst byte", first_dec(), 8'h81);
    chk("post rst pops", rd_cnt, 1);
    chk("post rst framing", frame_err, 0);

    tick_mode = 2;
    bp = 32;
    clr();
    expq.delete();
    n = 24;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      expq.push_back(b);
      idle($urandom_range(0, 400));
    end
    wait_done("rand", n, 24 * 400);
    idle(5);
    chk("rand frames", dec.size(), n);
    bad = 0;
    foreach (expq[i])
      if (i >= dec.size() || dec[i] !== expq[i]) bad++;
    chk("rand byte mismatches", bad, 0);
    chk("rand pops", rd_cnt, n);
    chk("rand underflow", rd_under, 0);
    chk("rand pop at start", rd_misalign, 0);
    chk("rand framing", frame_err, 0);
    chk("rand idle tx", tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
